// File: rtl/password_display_unit.sv
// password_display_unit: clock divider, 4-bit serial password checker with timeout, 4-digit 7-segment driver
module password_display_unit #(
    parameter int         DIV_MAX        = 24999999,
    parameter int         DIV_WIDTH      = 25,
    parameter logic [3:0] PASSWORD       = 4'b1011,
    parameter int         TIMEOUT_CYCLES = 500000000,
    parameter int         SCAN_MAX       = 49999
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       StartValidation,
    input  logic       SelectValue,
    input  logic       ConfirmButton,
    input  logic [2:0] DisplayMode,
    output logic       DivClk,
    output logic       CurrPass,
    output logic       WrongPass,
    output logic       TimeOut,
    output logic       DisplayValue,
    output logic [1:0] DisplayIndex,
    output logic [3:0] Anodes,
    output logic [7:0] Cathodes
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SCAN_MAX + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_ENTRY, ST_CORRECT, ST_WRONG, ST_TIMEOUT} state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [TW-1:0]        tcnt;
    logic [SW-1:0]        scan_cnt;
    logic [1:0]           digit;
    logic [2:0]           code;
    logic [2:0]           start_sr, sel_sr, conf_sr;
    logic [7:0]           seg;

    // bit [1] is the synchronized level, bit [2] its previous value
    wire start_lvl  = start_sr[1];
    wire start_edge = start_sr[1] & ~start_sr[2];
    wire sel_edge   = sel_sr[1] & ~sel_sr[2];
    wire conf_edge  = conf_sr[1] & ~conf_sr[2];

    // two-flop synchronizers plus one delay stage for edge detection
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            start_sr <= '0;
            sel_sr   <= '0;
            conf_sr  <= '0;
        end else begin
            start_sr <= {start_sr[1:0], StartValidation};
            sel_sr   <= {sel_sr[1:0], SelectValue};
            conf_sr  <= {conf_sr[1:0], ConfirmButton};
        end
    end

    // divider: DivClk toggles once per DIV_MAX+1 cycles
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
            DivClk  <= 1'b0;
        end else if (div_cnt == DIV_WIDTH'(DIV_MAX)) begin
            div_cnt <= '0;
            DivClk  <= ~DivClk;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    // checker FSM; start edge restarts from anywhere and outranks button edges
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= ST_IDLE;
            code         <= '0;
            tcnt         <= '0;
            DisplayIndex <= 2'd0;
            DisplayValue <= 1'b0;
            CurrPass     <= 1'b0;
            WrongPass    <= 1'b0;
            TimeOut      <= 1'b0;
        end else if (start_edge) begin
            state        <= ST_ENTRY;
            code         <= '0;
            tcnt         <= '0;
            DisplayIndex <= 2'd0;
            DisplayValue <= 1'b0;
            CurrPass     <= 1'b0;
            WrongPass    <= 1'b0;
            TimeOut      <= 1'b0;
        end else if (state == ST_ENTRY) begin
            if (!start_lvl) begin
                state <= ST_IDLE;
            end else if (conf_edge) begin
                tcnt <= '0;
                if (DisplayIndex != 2'd3) begin
                    code[2'd2 - DisplayIndex] <= DisplayValue;
                    DisplayIndex <= DisplayIndex + 2'd1;
                    DisplayValue <= 1'b0;
                end else if ({code, DisplayValue} == PASSWORD) begin
                    state    <= ST_CORRECT;
                    CurrPass <= 1'b1;
                end else begin
                    state     <= ST_WRONG;
                    WrongPass <= 1'b1;
                end
            end else begin
                if (sel_edge)
                    DisplayValue <= ~DisplayValue;
                if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state   <= ST_TIMEOUT;
                    TimeOut <= 1'b1;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

    // digit scan: each digit is shown for SCAN_MAX+1 cycles
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scan_cnt <= '0;
            digit    <= 2'd0;
        end else if (scan_cnt == SW'(SCAN_MAX)) begin
            scan_cnt <= '0;
            digit    <= digit + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // segment pattern for the digit currently selected
    always_comb begin
        seg = 8'hFF;
        case (DisplayMode)
            3'b000:  seg = digit < DisplayIndex ? 8'hBF :
                           digit == DisplayIndex ? (DisplayValue ? 8'hF9 : 8'hC0) : 8'hFF;
            3'b001:  seg = digit == 2'd0 ? 8'h8E : digit == 2'd1 ? 8'hC1 : 8'hC7;
            3'b010:  seg = digit == 2'd0 ? 8'h86 : digit == 2'd3 ? 8'hA3 : 8'hAF;
            3'b011:  seg = 8'hBF;
            default: seg = 8'hFF;
        endcase
    end

    // registered display outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Anodes   <= 4'b1111;
            Cathodes <= 8'hFF;
        end else begin
            Anodes   <= ~(4'b0001 << digit);
            Cathodes <= seg;
        end
    end
endmodule

// File: tb/tb_password_display_unit.sv
// tb_password_display_unit: directed bench with a cycle-level behavioural model of the unit
module tb_password_display_unit;
    localparam int         DM = 3;
    localparam int         TC = 50;
    localparam int         SM = 3;
    localparam logic [3:0] PW = 4'b1011;

    logic       Clk = 0, Reset_n = 1;
    logic       StartValidation = 0, SelectValue = 0, ConfirmButton = 0;
    logic [2:0] DisplayMode = 0;
    logic       DivClk, CurrPass, WrongPass, TimeOut, DisplayValue;
    logic [1:0] DisplayIndex;
    logic [3:0] Anodes;
    logic [7:0] Cathodes;

    password_display_unit #(
        .DIV_MAX(DM), .DIV_WIDTH(2), .PASSWORD(PW), .TIMEOUT_CYCLES(TC), .SCAN_MAX(SM)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .StartValidation(StartValidation),
        .SelectValue(SelectValue), .ConfirmButton(ConfirmButton), .DisplayMode(DisplayMode),
        .DivClk(DivClk), .CurrPass(CurrPass), .WrongPass(WrongPass), .TimeOut(TimeOut),
        .DisplayValue(DisplayValue), .DisplayIndex(DisplayIndex),
        .Anodes(Anodes), .Cathodes(Cathodes)
    );

    always #5 Clk = ~Clk;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: session phase, entered bits, cycles since reset and since last commit
    typedef enum {M_IDLE, M_ENTRY, M_OK, M_BAD, M_TO} ph_t;
    ph_t        ph = M_IDLE;
    logic [3:0] bits = 0;
    int         idx = 0, idle = 0, n = 0;
    bit         val = 0;
    logic [7:0] e_cath = 8'hFF;
    logic [3:0] e_an = 4'hF;
    logic [2:0] hs = 0, hl = 0, hc = 0;
    logic [7:0] msg [3][4] = '{'{8'h8E, 8'hC1, 8'hC7, 8'hC7},
                               '{8'h86, 8'hAF, 8'hAF, 8'hA3},
                               '{8'hBF, 8'hBF, 8'hBF, 8'hBF}};

    function automatic logic [7:0] digit_code(input int d, input logic [2:0] m, input int i, input bit v);
        if (m == 0) return d < i ? 8'hBF : d == i ? (v ? 8'hF9 : 8'hC0) : 8'hFF;
        if (m <= 3) return msg[m-1][d];
        return 8'hFF;
    endfunction

    task automatic model_reset();
        n = 0; ph = M_IDLE; bits = 0; idx = 0; val = 0; idle = 0;
        e_cath = 8'hFF; e_an = 4'hF; hs = 0; hl = 0; hc = 0;
    endtask

    // predict the effect of the coming clock edge from the inputs that edge will see
    task automatic model_step();
        int d;
        bit start_l, start_e, sel_e, cf_e;
        d = (n / (SM + 1)) % 4;
        e_an = ~(4'b0001 << d);
        e_cath = digit_code(d, DisplayMode, idx, val);
        start_l = hs[1];
        start_e = hs[1] & ~hs[2];
        sel_e = hl[1] & ~hl[2];
        cf_e = hc[1] & ~hc[2];
        hs = {hs[1:0], StartValidation};
        hl = {hl[1:0], SelectValue};
        hc = {hc[1:0], ConfirmButton};
        n++;
        if (start_e) begin
            ph = M_ENTRY; bits = 0; idx = 0; val = 0; idle = 0;
        end else if (ph == M_ENTRY) begin
            if (!start_l) ph = M_IDLE;
            else if (cf_e) begin
                bits[3-idx] = val;
                idle = 0;
                if (idx < 3) begin idx++; val = 0; end
                else ph = (bits == PW) ? M_OK : M_BAD;
            end else begin
                if (sel_e) val = ~val;
                idle++;
                if (idle == TC) ph = M_TO;
            end
        end
    endtask

    // compare every output against the model on the falling edge
    always @(negedge Clk) begin
        if (!Reset_n) model_reset();
        chk("DivClk", DivClk, (n / (DM + 1)) % 2);
        chk("flags", {CurrPass, WrongPass, TimeOut}, {ph == M_OK, ph == M_BAD, ph == M_TO});
        chk("index/value", {DisplayIndex, DisplayValue}, {idx[1:0], val});
        chk("Anodes", Anodes, e_an);
        chk("Cathodes", Cathodes, e_cath);
        if (Reset_n) model_step();
    end

    task automatic step(input int k);
        repeat (k) begin @(posedge Clk); #2; end
    endtask

    task automatic press(input bit conf);
        if (conf) ConfirmButton = 1; else SelectValue = 1;
        step(1);
        ConfirmButton = 0; SelectValue = 0;
        step(3);
    endtask

    task automatic start();
        StartValidation = 0;
        step(3);
        StartValidation = 1;
        step(3);
    endtask

    task automatic scan_check(input string nm, input logic [31:0] codes);
        int w;
        logic [3:0] an;
        w = 0;
        while (Anodes != 4'b1110 && w < 20) begin step(1); w++; end
        chk({nm, " scan sync"}, Anodes, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            an = ~(4'b0001 << i);
            chk({nm, " anodes"}, Anodes, an);
            chk({nm, " cathodes"}, Cathodes, codes[31-8*i -: 8]);
            step(4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] pat;
        logic [3:0]  seq;
        int cnt;
        pat = 16'b0111_1000_0111_1000;
        seq = 4'b1011;
        #1 Reset_n = 0;
        #1 chk("reset anodes", Anodes, 4'b1111);
        chk("reset cathodes", Cathodes, 8'hFF);
        step(2);
        Reset_n = 1;
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk("divider pattern", DivClk, pat[i]);
        end
        step(5);
        chk("divider high mid-period", DivClk, 1);
        Reset_n = 0;
        #1 chk("async reset DivClk", DivClk, 0);
        step(2);
        Reset_n = 1;

        start();
        chk("start index", DisplayIndex, 0);
        for (int i = 0; i < 4; i++) begin
            if (seq[3-i]) press(0);
            chk("entry index", DisplayIndex, i);
            chk("entry value", DisplayValue, seq[3-i]);
            press(1);
        end
        chk("correct CurrPass", CurrPass, 1);
        chk("correct others", {WrongPass, TimeOut}, 0);
        step(20);
        chk("CurrPass held", CurrPass, 1);

        start();
        for (int i = 0; i < 4; i++) begin press(0); press(1); end
        chk("wrong WrongPass", WrongPass, 1);
        chk("wrong CurrPass", CurrPass, 0);
        start();
        chk("restart WrongPass", WrongPass, 0);
        chk("restart index", DisplayIndex, 0);

        SelectValue = 1;
        step(10);
        chk("held select toggles once", DisplayValue, 1);
        SelectValue = 0;
        step(3);
        chk("held select released", DisplayValue, 1);
        press(1);
        press(1);
        press(0);
        chk("display setup", {DisplayIndex, DisplayValue}, 3'b101);
        scan_check("mode 000", 32'hBFBFF9FF);
        DisplayMode = 3'b001; step(2);
        scan_check("mode FULL", 32'h8EC1C7C7);
        DisplayMode = 3'b010; step(2);
        scan_check("mode Erro", 32'h86AFAFA3);
        DisplayMode = 3'b011; step(2);
        scan_check("mode dashes", 32'hBFBFBFBF);
        DisplayMode = 3'b110; step(2);
        scan_check("mode blank", 32'hFFFFFFFF);
        DisplayMode = 3'b000;

        start();
        ConfirmButton = 1;
        step(1);
        ConfirmButton = 0;
        cnt = 0;
        while (!TimeOut && cnt < 200) begin step(1); cnt++; end
        chk("timeout latency", cnt, 52);
        chk("timeout others", {CurrPass, WrongPass}, 0);

        StartValidation = 0;
        step(3);
        StartValidation = 1;
        ConfirmButton = 1;
        step(1);
        ConfirmButton = 0;
        step(4);
        chk("start beats confirm index", DisplayIndex, 0);
        chk("start clears TimeOut", TimeOut, 0);
        press(1);
        chk("later confirm advances", DisplayIndex, 1);
        StartValidation = 0;
        step(4);
        chk("abort flags", {CurrPass, WrongPass, TimeOut}, 0);
        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
